// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_REL = 2'b01,
    PC_ABS = 2'b10
  } pc_src_t;

  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_buffer.sv
// In-order ring of fetched words: entries are allocated at request time and
// filled by responses in request order, then popped by decode.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alloc,
  input  logic [WIDTH-1:0]   alloc_pc,
  input  logic               fill,
  input  logic [INSTR_W-1:0] fill_data,
  input  logic               pop,
  output logic               head_valid,
  output logic [WIDTH-1:0]   head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [AW:0]        alloc_cnt,
  output logic [AW:0]        unfilled_cnt
);

  logic [WIDTH-1:0]   pc_mem_r    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_r [DEPTH];
  logic [DEPTH-1:0]   filled_r;
  logic [AW-1:0]      alloc_ptr_r;
  logic [AW-1:0]      fill_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        alloc_cnt_r;
  logic [AW:0]        unfilled_cnt_r;
  logic               do_fill_s;

  // A response with nothing awaiting data is a memory protocol error and is ignored.
  assign do_fill_s = fill && (unfilled_cnt_r != {(AW+1){1'b0}});

  // Entry storage, pointers and occupancy counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= {WIDTH{1'b0}};
        instr_mem_r[i] <= {INSTR_W{1'b0}};
      end
      filled_r       <= {DEPTH{1'b0}};
      alloc_ptr_r    <= {AW{1'b0}};
      fill_ptr_r     <= {AW{1'b0}};
      rd_ptr_r       <= {AW{1'b0}};
      alloc_cnt_r    <= {(AW+1){1'b0}};
      unfilled_cnt_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      filled_r       <= {DEPTH{1'b0}};
      alloc_ptr_r    <= {AW{1'b0}};
      fill_ptr_r     <= {AW{1'b0}};
      rd_ptr_r       <= {AW{1'b0}};
      alloc_cnt_r    <= {(AW+1){1'b0}};
      unfilled_cnt_r <= {(AW+1){1'b0}};
    end else begin
      // alloc may target the slot being popped; both clear its filled bit.
      if (pop) begin
        filled_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r           <= rd_ptr_r + AW'(1);
      end
      if (alloc) begin
        pc_mem_r[alloc_ptr_r] <= alloc_pc;
        filled_r[alloc_ptr_r] <= 1'b0;
        alloc_ptr_r           <= alloc_ptr_r + AW'(1);
      end
      if (do_fill_s) begin
        instr_mem_r[fill_ptr_r] <= fill_data;
        filled_r[fill_ptr_r]    <= 1'b1;
        fill_ptr_r              <= fill_ptr_r + AW'(1);
      end
      alloc_cnt_r    <= alloc_cnt_r + (AW+1)'(alloc) - (AW+1)'(pop);
      unfilled_cnt_r <= unfilled_cnt_r + (AW+1)'(alloc) - (AW+1)'(do_fill_s);
    end
  end

  assign head_valid   = filled_r[rd_ptr_r];
  assign head_pc      = pc_mem_r[rd_ptr_r];
  assign head_instr   = instr_mem_r[rd_ptr_r];
  assign alloc_cnt    = alloc_cnt_r;
  assign unfilled_cnt = unfilled_cnt_r;

endmodule

// File: rtl/fetch_unit.sv
// RISC-V fetch front end: fetch PC, redirect handling, request issue and stale-response dropping.
// Optional build macro FETCH_PERF_EN adds saturating redirect/drop counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         redir_src,
  input  logic [WIDTH-1:0]   redir_pc,
  input  logic [31:0]        redir_imm,
  input  logic [31:0]        redir_alu,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [WIDTH-1:0]   imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [WIDTH-1:0]   if_pc,
  output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_redirects,
  output logic [31:0]        perf_dropped
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  logic [WIDTH-1:0]   fetch_pc_r;
  logic [CW-1:0]      drop_cnt_r;
  logic               redirect_s;
  logic [WIDTH-1:0]   raw_target_s;
  logic [WIDTH-1:0]   target_s;
  logic               pop_s;
  logic               accept_s;
  logic               fill_s;
  logic [CW-1:0]      occ_s;
  logic [CW:0]        pending_s;
  logic               head_valid_s;
  logic [WIDTH-1:0]   head_pc_s;
  logic [INSTR_W-1:0] head_instr_s;
  logic [CW-1:0]      alloc_cnt_s;
  logic [CW-1:0]      unfilled_cnt_s;

  // Redirect decode and word-aligned target selection
  always_comb begin
    redirect_s   = 1'b0;
    raw_target_s = fetch_pc_r;
    case (pc_src_t'(redir_src))
      PC_REL: begin
        redirect_s   = 1'b1;
        raw_target_s = redir_pc + WIDTH'($signed(redir_imm));
      end
      PC_ABS: begin
        redirect_s   = 1'b1;
        raw_target_s = WIDTH'(redir_alu);
      end
      default: begin
        redirect_s   = 1'b0;
        raw_target_s = fetch_pc_r;
      end
    endcase
    target_s = raw_target_s & ALIGN_MASK;
  end

  assign pop_s    = head_valid_s && if_ready && !redirect_s && !rst;
  assign accept_s = imem_req_valid && imem_req_ready;
  assign fill_s   = imem_rsp_valid && (drop_cnt_r == {CW{1'b0}});
  // Counting the head entry leaving this cycle lets a 2-deep buffer sustain one word per cycle.
  assign occ_s     = alloc_cnt_s - CW'(pop_s);
  assign pending_s = {1'b0, occ_s} + {1'b0, drop_cnt_r};
  assign imem_req_addr = fetch_pc_r;

  // Request issue: room in the buffer and in the outstanding-response budget
  always_comb begin
    if (!rst && !redirect_s && (occ_s < CW'(DEPTH)) && (pending_s < (CW+1)'(DEPTH))) begin
      imem_req_valid = 1'b1;
    end else begin
      imem_req_valid = 1'b0;
    end
  end

  // Fetch PC and count of in-flight responses that belong to a squashed path
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      drop_cnt_r <= {CW{1'b0}};
    end else if (redirect_s) begin
      fetch_pc_r <= target_s;
      drop_cnt_r <= drop_cnt_r + unfilled_cnt_s - CW'(imem_rsp_valid);
    end else begin
      if (accept_s) begin
        fetch_pc_r <= fetch_pc_r + WIDTH'(INSTR_BYTES);
      end
      if (imem_rsp_valid && (drop_cnt_r != {CW{1'b0}})) begin
        drop_cnt_r <= drop_cnt_r - CW'(1);
      end
    end
  end

  fetch_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk          (clk),
    .rst          (rst),
    .flush        (redirect_s),
    .alloc        (accept_s),
    .alloc_pc     (fetch_pc_r),
    .fill         (fill_s),
    .fill_data    (imem_rsp_data),
    .pop          (pop_s),
    .head_valid   (head_valid_s),
    .head_pc      (head_pc_s),
    .head_instr   (head_instr_s),
    .alloc_cnt    (alloc_cnt_s),
    .unfilled_cnt (unfilled_cnt_s)
  );

  // Decode-side outputs are held at zero while reset is asserted
  always_comb begin
    if (rst) begin
      if_valid = 1'b0;
      if_pc    = {WIDTH{1'b0}};
      if_instr = {INSTR_W{1'b0}};
    end else begin
      if_valid = head_valid_s;
      if_pc    = head_pc_s;
      if_instr = head_instr_s;
    end
  end

`ifdef FETCH_PERF_EN
  logic discard_s;
  assign discard_s = imem_rsp_valid && ((drop_cnt_r != {CW{1'b0}}) || redirect_s);

  // Saturating redirect and discarded-response counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects <= 32'd0;
      perf_dropped   <= 32'd0;
    end else begin
      if (redirect_s && (perf_redirects != 32'hFFFF_FFFF)) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
      if (discard_s && (perf_dropped != 32'hFFFF_FFFF)) begin
        perf_dropped <= perf_dropped + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory of selectable latency.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  redir_src;
  logic [31:0] redir_pc, redir_imm, redir_alu;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;

  int n_vec = 0;
  int n_err = 0;
  int lat = 1;
  int acc_cnt = 0;
  logic [31:0] req_log [8];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redir_src      (redir_src),
    .redir_pc       (redir_pc),
    .redir_imm      (redir_imm),
    .redir_alu      (redir_alu),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory: accepts every request, answers in order after lat cycles.
  initial begin : mem_model
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          cyc = 0;
    logic        acc, flush;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #3;
      acc   = imem_req_valid && imem_req_ready;
      a     = imem_req_addr;
      flush = rst;
      @(posedge clk);
      #1;
      cyc++;
      if (flush) begin
        q_addr.delete();
        q_due.delete();
        acc_cnt = 0;
      end else begin
        if (imem_rsp_valid) begin
          void'(q_addr.pop_front());
          void'(q_due.pop_front());
        end
        if (acc) begin
          q_addr.push_back(a);
          q_due.push_back(cyc + lat - 1);
          req_log[acc_cnt % 8] = a;
          acc_cnt++;
        end
      end
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(q_addr[0]);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Hold reset two cycles; returns in the first cycle after release.
  task automatic do_reset(input int l, input logic rdy);
    @(posedge clk); #1;
    rst = 1'b1; redir_src = 2'b00; if_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    lat = l; rst = 1'b0; if_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = if_valid;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  initial begin : stim
    logic found;
    rst = 1'b1; redir_src = 2'b00; redir_pc = 32'h0; redir_imm = 32'h0; redir_alu = 32'h0;
    imem_req_ready = 1'b1; if_ready = 1'b0;

    // Reset state
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);

    // Streaming with 1-cycle memory
    next_cycle(); rst = 1'b0; if_ready = 1'b1;
    @(negedge clk);
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_req_addr0", imem_req_addr, 32'h0);
    @(negedge clk);
    chk("t1_req_addr1", imem_req_addr, 32'h4);
    chk("t1_early_valid", 32'(if_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_valid", 32'(if_valid), 32'd1);
      chk("t1_pc", if_pc, 32'(k * 4));
      chk("t1_instr", if_instr, instr_of(32'(k * 4)));
    end

    // Decode stalled: fetch stops at buffer depth
    do_reset(1, 1'b0);
    repeat (10) @(negedge clk);
    chk("t2_req_count", 32'(acc_cnt), 32'd2);
    chk("t2_req0", req_log[0], 32'h0);
    chk("t2_req1", req_log[1], 32'h4);
    chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
    next_cycle(); if_ready = 1'b1;
    @(negedge clk);
    chk("t2_valid0", 32'(if_valid), 32'd1);
    chk("t2_pc0", if_pc, 32'h0);
    @(negedge clk);
    chk("t2_valid1", 32'(if_valid), 32'd1);
    chk("t2_pc1", if_pc, 32'h4);

    // PC-relative redirect with two responses in flight
    do_reset(4, 1'b1);
    next_cycle(); next_cycle();
    redir_src = 2'b01; redir_pc = 32'h100; redir_imm = 32'hFFFF_FFF0;
    @(negedge clk);
    chk("t3_req_in_redir", 32'(imem_req_valid), 32'd0);
    next_cycle(); redir_src = 2'b00;
    wait_valid("t3_wait_valid");
    chk("t3_pc", if_pc, 32'hF0);
    chk("t3_instr", if_instr, instr_of(32'hF0));

    // Absolute redirect: bit 0 and bit 1 cleared, 2-edge refill
    do_reset(1, 1'b1);
    repeat (5) next_cycle();
    redir_src = 2'b10; redir_alu = 32'h203;
    @(negedge clk);
    chk("t4_req_in_redir", 32'(imem_req_valid), 32'd0);
    next_cycle(); redir_src = 2'b00;
    @(negedge clk);
    chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_req_addr", imem_req_addr, 32'h200);
    chk("t4_valid_e1", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("t4_valid_e2", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("t4_valid_e3", 32'(if_valid), 32'd1);
    chk("t4_pc", if_pc, 32'h200);
    chk("t4_instr", if_instr, instr_of(32'h200));

    // 3-cycle memory, redirect coinciding with a response
    do_reset(3, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_rsp_valid) begin
        found = 1'b1;
        #1;
        redir_src = 2'b01; redir_pc = 32'h1000; redir_imm = 32'h20;
      end
    end
    chk("t5_rsp_seen", 32'(found), 32'd1);
    next_cycle(); redir_src = 2'b00;
    wait_valid("t5_wait_valid");
    chk("t5_pc0", if_pc, 32'h1020);
    chk("t5_instr0", if_instr, instr_of(32'h1020));
    @(negedge clk);
    chk("t5_valid1", 32'(if_valid), 32'd1);
    chk("t5_pc1", if_pc, 32'h1024);

    // Reset while busy
    do_reset(1, 1'b1);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("t6_pre_valid", 32'(if_valid), 32'd1);
    next_cycle(); rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", 32'(if_valid), 32'd0);
    chk("t6_rst_req", 32'(imem_req_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t6_after_valid", 32'(if_valid), 32'd0);
    chk("t6_after_req", 32'(imem_req_valid), 32'd0);
    chk("t6_after_pc", if_pc, 32'h0);
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    chk("t6_rel_req", 32'(imem_req_valid), 32'd1);
    chk("t6_rel_addr", imem_req_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
